surface_pooling_scanner: RTL and testbench

Downstream consumer of the time-surface memory in the gradient-map pipeline. On a start pulse it sweeps every grid cell once through the memory's 2-cycle read port and sums decayed values over non-overlapping POOL×POOL regions. It then streams the region sums to the classifier front end over a valid/ready handshake. One scan produces one pooled feature frame.

---
 rtl/surface_pooling_scanner.sv | 272 +++++++++++++++++++++++++++
 tb/tb_surface_pooling_scanner.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/surface_pooling_scanner.sv
// Sweeps the time-surface memory once per start, sums decayed values over
// POOL x POOL regions, then streams the region sums over valid/ready.
module surface_pooling_scanner #(
  parameter int GRID_SIZE  = 16,
  parameter int ADDR_BITS  = 8,
  parameter int VALUE_BITS = 8,
  parameter int POOL       = 4,
  parameter int SUM_BITS   = 12,
  localparam int REG_SIDE  = GRID_SIZE / POOL,
  localparam int NREG      = REG_SIDE * REG_SIDE,
  localparam int IDX_BITS  = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  rd_en,
  output logic [ADDR_BITS-1:0]  rd_addr,
  input  logic [VALUE_BITS-1:0] rd_value,
  output logic                  feat_valid,
  input  logic                  feat_ready,
  output logic [SUM_BITS-1:0]   feat_data,
  output logic [IDX_BITS-1:0]   feat_index,
  output logic                  feat_last,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  // Handshake: a feature word transfers in any cycle where feat_valid and
  // feat_ready are both high; while feat_valid is high and feat_ready is low,
  // feat_data/feat_index/feat_last hold and feat_valid does not drop.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

  localparam logic [ADDR_BITS-1:0] POOL_A    = ADDR_BITS'(POOL);
  localparam logic [ADDR_BITS-1:0] GRID_A    = ADDR_BITS'(GRID_SIZE);
  localparam logic [ADDR_BITS-1:0] RSIDE_A   = ADDR_BITS'(REG_SIDE);
  localparam logic [ADDR_BITS-1:0] POOL_MAX  = ADDR_BITS'(POOL - 1);
  localparam logic [ADDR_BITS-1:0] RSIDE_MAX = ADDR_BITS'(REG_SIDE - 1);
  localparam logic [IDX_BITS-1:0]  IDX_LAST  = IDX_BITS'(NREG - 1);

  state_t state_q, state_d;
  logic   drain_q, drain_d;

  // Scan position of the address currently on rd_addr.
  logic [ADDR_BITS-1:0] cx_q, cx_d, cy_q, cy_d, rx_q, rx_d, ry_q, ry_d;
  logic [ADDR_BITS-1:0] cx_n, cy_n, rx_n, ry_n;

  logic                 busy_q, busy_d;
  logic                 rd_en_q, rd_en_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic                 feat_valid_q, feat_valid_d;
  logic [SUM_BITS-1:0]  feat_data_q, feat_data_d;
  logic [IDX_BITS-1:0]  feat_index_q, feat_index_d;
  logic                 feat_last_q, feat_last_d;
  logic                 done_q, done_d;

  // Return-path tags: stage 2 lines up with rd_value for the same sample.
  logic                t1_valid_q, t1_valid_d, t2_valid_q, t2_valid_d;
  logic                t1_last_q, t1_last_d, t2_last_q, t2_last_d;
  logic [IDX_BITS-1:0] t1_region_q, t1_region_d, t2_region_q, t2_region_d;

  logic [SUM_BITS-1:0] acc_q, acc_d;
  logic [SUM_BITS-1:0] value_ext;
  logic [SUM_BITS-1:0] sum_buf_q [NREG];
  logic                buf_we;
  logic [IDX_BITS-1:0] buf_waddr;
  logic [SUM_BITS-1:0] buf_wdata;

  logic scan_last;

  function automatic logic [ADDR_BITS-1:0] addr_of(
    input logic [ADDR_BITS-1:0] ry,
    input logic [ADDR_BITS-1:0] rx,
    input logic [ADDR_BITS-1:0] cy,
    input logic [ADDR_BITS-1:0] cx
  );
    return (ry * POOL_A + cy) * GRID_A + rx * POOL_A + cx;
  endfunction

  assign value_ext = {{(SUM_BITS-VALUE_BITS){1'b0}}, rd_value};
  assign scan_last = (cx_q == POOL_MAX) && (cy_q == POOL_MAX) &&
                     (rx_q == RSIDE_MAX) && (ry_q == RSIDE_MAX);

  // Region-major stepping: cx fastest, then cy, rx, ry.
  always_comb begin
    cx_n = cx_q + ADDR_BITS'(1);
    cy_n = cy_q;
    rx_n = rx_q;
    ry_n = ry_q;
    if (cx_q == POOL_MAX) begin
      cx_n = '0;
      cy_n = cy_q + ADDR_BITS'(1);
      if (cy_q == POOL_MAX) begin
        cy_n = '0;
        rx_n = rx_q + ADDR_BITS'(1);
        if (rx_q == RSIDE_MAX) begin
          rx_n = '0;
          ry_n = ry_q + ADDR_BITS'(1);
        end
      end
    end
  end

  always_comb begin
    t1_valid_d  = (state_q == ST_SCAN);
    t1_last_d   = (cx_q == POOL_MAX) && (cy_q == POOL_MAX);
    t1_region_d = IDX_BITS'(ry_q * RSIDE_A + rx_q);
    t2_valid_d  = t1_valid_q;
    t2_last_d   = t1_last_q;
    t2_region_d = t1_region_q;

    acc_d     = acc_q;
    buf_we    = 1'b0;
    buf_waddr = t2_region_q;
    buf_wdata = acc_q + value_ext;
    if (t2_valid_q) begin
      if (t2_last_q) begin
        buf_we = 1'b1;
        acc_d  = '0;
      end else begin
        acc_d = acc_q + value_ext;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    rx_d         = rx_q;
    ry_d         = ry_q;
    rd_en_d      = rd_en_q;
    rd_addr_d    = rd_addr_q;
    feat_valid_d = feat_valid_q;
    feat_data_d  = feat_data_q;
    feat_index_d = feat_index_q;
    feat_last_d  = feat_last_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SCAN;
          cx_d      = '0;
          cy_d      = '0;
          rx_d      = '0;
          ry_d      = '0;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end
      end
      ST_SCAN: begin
        if (scan_last) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end else begin
          cx_d      = cx_n;
          cy_d      = cy_n;
          rx_d      = rx_n;
          ry_d      = ry_n;
          rd_addr_d = addr_of(ry_n, rx_n, cy_n, cx_n);
        end
      end
      ST_DRAIN: begin
        // Two cycles with the last address held let the final samples land.
        if (drain_q) begin
          state_d      = ST_OUTPUT;
          rd_en_d      = 1'b0;
          rd_addr_d    = '0;
          feat_valid_d = 1'b1;
          feat_index_d = '0;
          feat_data_d  = sum_buf_q[0];
          feat_last_d  = (IDX_LAST == '0);
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_OUTPUT: begin
        if (feat_valid_q && feat_ready) begin
          if (feat_index_q == IDX_LAST) begin
            state_d      = ST_IDLE;
            feat_valid_d = 1'b0;
            feat_data_d  = '0;
            feat_index_d = '0;
            feat_last_d  = 1'b0;
            done_d       = 1'b1;
          end else begin
            feat_index_d = feat_index_q + IDX_BITS'(1);
            feat_data_d  = sum_buf_q[feat_index_d];
            feat_last_d  = (feat_index_d == IDX_LAST);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      drain_q      <= 1'b0;
      cx_q         <= '0;
      cy_q         <= '0;
      rx_q         <= '0;
      ry_q         <= '0;
      busy_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      feat_valid_q <= 1'b0;
      feat_data_q  <= '0;
      feat_index_q <= '0;
      feat_last_q  <= 1'b0;
      done_q       <= 1'b0;
      t1_valid_q   <= 1'b0;
      t1_last_q    <= 1'b0;
      t1_region_q  <= '0;
      t2_valid_q   <= 1'b0;
      t2_last_q    <= 1'b0;
      t2_region_q  <= '0;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      rx_q         <= rx_d;
      ry_q         <= ry_d;
      busy_q       <= busy_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      feat_valid_q <= feat_valid_d;
      feat_data_q  <= feat_data_d;
      feat_index_q <= feat_index_d;
      feat_last_q  <= feat_last_d;
      done_q       <= done_d;
      t1_valid_q   <= t1_valid_d;
      t1_last_q    <= t1_last_d;
      t1_region_q  <= t1_region_d;
      t2_valid_q   <= t2_valid_d;
      t2_last_q    <= t2_last_d;
      t2_region_q  <= t2_region_d;
      acc_q        <= acc_d;
    end
  end

  // Sum buffer needs no reset: every entry is rewritten before it is shown.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      sum_buf_q[buf_waddr] <= buf_wdata;
    end
  end

  assign busy       = busy_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign feat_valid = feat_valid_q;
  assign feat_data  = feat_data_q;
  assign feat_index = feat_index_q;
  assign feat_last  = feat_last_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_surface_pooling_scanner.sv
// Bench for surface_pooling_scanner: memory model with a 2-cycle read,
// region-sum reference model and randomized backpressure.
module tb_surface_pooling_scanner;

  localparam int G    = 16;
  localparam int P    = 4;
  localparam int NREG = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_value;
  logic        feat_valid;
  logic        feat_ready;
  logic [11:0] feat_data;
  logic [3:0]  feat_index;
  logic        feat_last;
  logic        done;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] exp_q[$];
  logic [7:0]  surface [256];
  logic [7:0]  mem_addr_s1;
  logic        mem_en_s1;

  surface_pooling_scanner dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_value   (rd_value),
    .feat_valid (feat_valid),
    .feat_ready (feat_ready),
    .feat_data  (feat_data),
    .feat_index (feat_index),
    .feat_last  (feat_last),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Memory: address at t produces its value during t+2.
  always @(posedge clk) begin
    mem_addr_s1 <= rd_addr;
    mem_en_s1   <= rd_en;
    if (mem_en_s1) rd_value <= surface[mem_addr_s1];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_addr(input int k);
    int r, ry, rx, cy, cx;
    r  = k / (P * P);
    ry = r / (G / P);
    rx = r % (G / P);
    cy = (k % (P * P)) / P;
    cx = k % P;
    return (ry * P + cy) * G + rx * P + cx;
  endfunction

  function automatic logic [11:0] region_sum(input int r);
    int s, ry, rx;
    s  = 0;
    ry = r / (G / P);
    rx = r % (G / P);
    for (int cy = 0; cy < P; cy++)
      for (int cx = 0; cx < P; cx++)
        s += int'(surface[(ry * P + cy) * G + rx * P + cx]);
    return 12'(s);
  endfunction

  task automatic fill_surface(input int mode);
    for (int i = 0; i < 256; i++) begin
      case (mode)
        0:       surface[i] = 8'd0;
        1:       surface[i] = 8'd255;
        2:       surface[i] = 8'(i);
        default: surface[i] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq({name, "_busy"}, 32'(busy), 0);
    check_eq({name, "_rd_en"}, 32'(rd_en), 0);
    check_eq({name, "_rd_addr"}, 32'(rd_addr), 0);
    check_eq({name, "_feat_valid"}, 32'(feat_valid), 0);
    check_eq({name, "_feat_data"}, 32'(feat_data), 0);
    check_eq({name, "_feat_index"}, 32'(feat_index), 0);
    check_eq({name, "_feat_last"}, 32'(feat_last), 0);
    check_eq({name, "_done"}, 32'(done), 0);
  endtask

  // Driver + scoreboard for one full frame; t is the cycle offset from S.
  task automatic run_frame(input string name, input bit bp, input bit strays);
    int  t, idx, scan_err, early_done;
    bit  rdy;
    exp_q.delete();
    for (int r = 0; r < NREG; r++) exp_q.push_back(region_sum(r));
    feat_ready = 1'b0;
    check_eq({name, "_idle_busy"}, 32'(busy), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    t = 1;
    scan_err = 0;
    while (t <= 258) begin
      if (rd_en !== 1'b1 || busy !== 1'b1) scan_err++;
      if (32'(rd_addr) !== 32'(exp_addr((t <= 256) ? t - 1 : 255))) scan_err++;
      if (strays && t == 10) start = 1'b1;
      step();
      start = 1'b0;
      t++;
    end
    check_eq({name, "_scan_errs"}, 32'(scan_err), 0);
    check_eq({name, "_rd_en_off"}, 32'(rd_en), 0);
    idx = 0;
    early_done = 0;
    while (idx < NREG && t < 2300) begin
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      feat_ready = rdy;
      if (strays && t == 260) start = 1'b1;
      if (feat_valid !== 1'b1) begin
        check_eq($sformatf("%s_valid_w%0d", name, idx), 32'(feat_valid), 1);
        break;
      end
      if (done !== 1'b0) early_done++;
      check_eq($sformatf("%s_index_w%0d", name, idx), 32'(feat_index), 32'(idx));
      check_eq($sformatf("%s_data_w%0d", name, idx), 32'(feat_data), 32'(exp_q[0]));
      check_eq($sformatf("%s_last_w%0d", name, idx), 32'(feat_last), 32'(idx == NREG - 1));
      if (rdy) begin
        void'(exp_q.pop_front());
        idx++;
      end
      step();
      start = 1'b0;
      t++;
    end
    feat_ready = 1'b0;
    check_eq({name, "_words"}, 32'(idx), NREG);
    check_eq({name, "_early_done"}, 32'(early_done), 0);
    check_eq({name, "_done"}, 32'(done), 1);
    check_eq({name, "_busy_end"}, 32'(busy), 0);
    check_eq({name, "_valid_end"}, 32'(feat_valid), 0);
    if (!bp) check_eq({name, "_done_cycle"}, 32'(t), 275);
    step();
    check_eq({name, "_done_pulse"}, 32'(done), 0);
    check_eq({name, "_still_idle"}, 32'(busy), 0);
  endtask

  task automatic run_mid_reset();
    int t;
    start = 1'b1;
    step();
    start = 1'b0;
    t = 1;
    while (t < 100) begin
      step();
      t++;
    end
    check_eq("midrst_busy_before", 32'(busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("midrst");
    check_eq("midrst_state", 32'(dbg_state), 0);
    step();
    check_eq("midrst_busy_after", 32'(busy), 0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    feat_ready = 1'b0;
    fill_surface(0);
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    fill_surface(0);
    run_frame("zero", 1'b0, 1'b0);
    fill_surface(1);
    run_frame("sat", 1'b0, 1'b0);
    fill_surface(2);
    run_frame("addr", 1'b0, 1'b0);
    fill_surface(3);
    run_frame("bp", 1'b1, 1'b0);
    fill_surface(3);
    run_frame("stray", 1'b0, 1'b1);
    fill_surface(3);
    run_mid_reset();
    fill_surface(3);
    run_frame("after_rst", 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
